// File: rtl/reg_dump_reader_pkg.sv
// Shared definitions for the register-dump reader.
// Holds the FSM state encoding, the ASCII constants used by the hex
// printer and the number of hex characters printed per 32-bit register.
package reg_dump_reader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_0       = 8'h30;
  localparam logic [7:0] ASCII_A_LC    = 8'h61;
  localparam logic [7:0] ASCII_LF      = 8'h0a;
  localparam logic [3:0] CHARS_PER_REG = 4'd8;

endpackage

// File: rtl/reg_dump_reader_if.sv
// Byte-stream interface between the register-dump reader and the UART TX path.
// Signals:
//   tx_valid - byte available on tx_data (driven by the source)
//   tx_data  - ASCII byte (driven by the source)
//   tx_ready - sink accepts the byte on a rising edge with tx_valid high
// Modports: master = byte source, slave = byte sink.
interface reg_dump_reader_if;

  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);

endinterface

// File: rtl/reg_dump_reader_nibble_to_hex_ascii.sv
// Pure combinational map from a 4-bit nibble to its lowercase hex ASCII
// character ('0'-'9', 'a'-'f'). Shared by the debug printers.
// Ports:
//   nibble - 4-bit value to print
//   ascii  - matching ASCII character
module nibble_to_hex_ascii
  import reg_dump_reader_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  // Decimal digits offset from '0', letters offset from 'a'.
  always_comb begin
    ascii = ASCII_0;
    if (nibble < 4'd10) begin
      ascii = ASCII_0 + {4'd0, nibble};
    end else begin
      ascii = ASCII_A_LC + {4'd0, nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/reg_dump_reader.sv
// Register-file dump reader. On a start pulse in IDLE it walks registers
// 0..NUM_REGS-1 over the debug read port, snapshots each value in a single
// LOAD cycle and streams it as 8 lowercase hex characters plus a newline.
// Ports:
//   clk, rstn   - clock (rising edge), asynchronous active-low reset
//   start       - dump request, only honoured in IDLE
//   dbg_reg_ra  - register index presented to the register file
//   dbg_reg_rd  - combinational read data for dbg_reg_ra
//   tx          - byte-stream source (tx_valid / tx_data / tx_ready)
//   busy        - high whenever the FSM is not in IDLE
//   done        - one-cycle pulse after the final newline is accepted
module reg_dump_reader
  import reg_dump_reader_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  output logic [ADDR_W-1:0]     dbg_reg_ra,
  input  logic [31:0]           dbg_reg_rd,
  reg_dump_reader_if.master     tx,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t              state_r,    state_s;
  logic [ADDR_W-1:0]   idx_r,      idx_s;
  logic [3:0]          char_cnt_r, char_cnt_s;
  logic [31:0]         shadow_r,   shadow_s;
  logic                handshake_s;
  logic [7:0]          hex_char_s;

  // The top nibble of the shifting snapshot is always the next character.
  nibble_to_hex_ascii u_hex (
    .nibble (shadow_r[31:28]),
    .ascii  (hex_char_s)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= IDLE;
      idx_r      <= '0;
      char_cnt_r <= 4'd0;
      shadow_r   <= 32'd0;
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      char_cnt_r <= char_cnt_s;
      shadow_r   <= shadow_s;
    end
  end

  // Next-state logic: snapshot in LOAD, shift out one nibble per accepted byte.
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    char_cnt_s  = char_cnt_r;
    shadow_s    = shadow_r;
    handshake_s = (state_r == SEND) && tx.tx_ready;
    case (state_r)
      IDLE: begin
        if (start) begin
          idx_s   = '0;
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        shadow_s   = dbg_reg_rd;
        char_cnt_s = 4'd0;
        state_s    = SEND;
      end
      SEND: begin
        if (handshake_s) begin
          if (char_cnt_r < CHARS_PER_REG) begin
            shadow_s   = {shadow_r[27:0], 4'h0};
            char_cnt_s = char_cnt_r + 4'd1;
          end else if (idx_r == LAST_IDX) begin
            state_s = DONE;
          end else begin
            idx_s   = idx_r + ADDR_W'(1);
            state_s = LOAD;
          end
        end else begin
          state_s = SEND;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state only, so they never depend on tx_ready.
  always_comb begin
    tx.tx_valid = 1'b0;
    tx.tx_data  = 8'h00;
    if (state_r == SEND) begin
      tx.tx_valid = 1'b1;
      if (char_cnt_r < CHARS_PER_REG) begin
        tx.tx_data = hex_char_s;
      end else begin
        tx.tx_data = ASCII_LF;
      end
    end else begin
      tx.tx_valid = 1'b0;
    end
  end

  assign dbg_reg_ra = idx_r;
  assign busy       = (state_r != IDLE);
  assign done       = (state_r == DONE);

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed self-checking bench for reg_dump_reader: a 32-register build and a
// 4-register build share one modelled register file.
module tb_reg_dump_reader;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start_a, start_b;
  logic [4:0]  ra_a, ra_b;
  logic [31:0] rd_a, rd_b;
  logic        busy_a, done_a, busy_b, done_b;
  logic [31:0] regs [32];

  reg_dump_reader_if if_a ();
  reg_dump_reader_if if_b ();

  always #5 clk = ~clk;

  assign rd_a = regs[ra_a];
  assign rd_b = regs[ra_b];

  reg_dump_reader dut_a (
    .clk(clk), .rstn(rstn), .start(start_a), .dbg_reg_ra(ra_a), .dbg_reg_rd(rd_a),
    .tx(if_a.master), .busy(busy_a), .done(done_a)
  );

  reg_dump_reader #(.NUM_REGS(4), .ADDR_W(5)) dut_b (
    .clk(clk), .rstn(rstn), .start(start_b), .dbg_reg_ra(ra_b), .dbg_reg_rd(rd_b),
    .tx(if_b.master), .busy(busy_b), .done(done_b)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  bytes_q [$];
  int          done_at, done_cnt, stable_err, hold_err, first_v;
  logic        busy_after;
  logic        timed_out;
  logic [71:0] exp_line;
  logic [7:0]  got;

  task automatic set_pattern();
    for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h11111111;
  endtask

  // Caller raises start at a negedge; the next posedge is E0 and the first
  // sample here (n=0) is the cycle right after E0.
  // mode 0: ready=1, 1: ready toggles, 2: ready low 50 cycles after first valid,
  // 3: ready=1 with extra start pulses during the dump.
  task automatic capture(input bit sel_b, input int mode, input int max_cyc);
    logic v, rdy, dn, bs;
    logic [7:0] d, prev_d;
    logic [4:0] ra;
    logic prev_stall;
    int n;
    bytes_q.delete();
    done_at = -1; done_cnt = 0; stable_err = 0; hold_err = 0; first_v = -1;
    busy_after = 1'b1; prev_stall = 1'b0; prev_d = 8'h00;
    @(negedge clk);
    if (sel_b) start_b = 1'b0; else start_a = 1'b0;
    for (n = 0; n < max_cyc; n++) begin
      if (n > 0) @(negedge clk);
      if (sel_b) begin
        v = if_b.tx_valid; d = if_b.tx_data; ra = ra_b; dn = done_b; bs = busy_b;
      end else begin
        v = if_a.tx_valid; d = if_a.tx_data; ra = ra_a; dn = done_a; bs = busy_a;
      end
      if (prev_stall && (v !== 1'b1 || d !== prev_d)) stable_err++;
      if (v && first_v < 0) first_v = n;
      if (dn) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      if (done_at >= 0 && n == done_at + 1) busy_after = bs;
      case (mode)
        1: rdy = (n % 2 == 0) ? 1'b0 : 1'b1;
        2: rdy = (first_v >= 0 && n < first_v + 50) ? 1'b0 : 1'b1;
        default: rdy = 1'b1;
      endcase
      if (mode == 2 && first_v >= 0 && n < first_v + 50 &&
          (v !== 1'b1 || d !== 8'h30 || ra !== 5'd0)) hold_err++;
      if (mode == 3) start_a = (done_at < 0 && n % 23 == 7) ? 1'b1 : 1'b0;
      if (sel_b) if_b.tx_ready = rdy; else if_a.tx_ready = rdy;
      if (v && rdy) bytes_q.push_back(d);
      prev_stall = v && !rdy;
      prev_d = d;
      if (done_at >= 0 && n >= done_at + 3) break;
    end
    timed_out = (done_at < 0) || (n >= max_cyc);
    start_a = 1'b0; start_b = 1'b0;
    if_a.tx_ready = 1'b1; if_b.tx_ready = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; start_a = 1'b0; start_b = 1'b0;
    if_a.tx_ready = 1'b1; if_b.tx_ready = 1'b1;
    set_pattern();
    @(negedge clk); @(negedge clk);
    n_checks++;
    if ({if_a.tx_valid, if_a.tx_data, ra_a, busy_a, done_a} !== 16'd0) begin
      n_fail++; $display("FAIL reset_a: got %h expected 0", {if_a.tx_valid, if_a.tx_data, ra_a, busy_a, done_a});
    end
    n_checks++;
    if ({if_b.tx_valid, if_b.tx_data, ra_b, busy_b, done_b} !== 16'd0) begin
      n_fail++; $display("FAIL reset_b: got %h expected 0", {if_b.tx_valid, if_b.tx_data, ra_b, busy_b, done_b});
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_dump();
    set_pattern();
    @(negedge clk); start_a = 1'b1;
    capture(1'b0, 0, 1000);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL full_timeout: got no done expected done"); end
    n_checks++; if (bytes_q.size() != 288) begin n_fail++; $display("FAIL full_bytes: got %0d expected 288", bytes_q.size()); end
    n_checks++; if (first_v != 1) begin n_fail++; $display("FAIL full_first_valid: got %0d expected 1", first_v); end
    n_checks++; if (done_at != 320) begin n_fail++; $display("FAIL full_done_cycle: got %0d expected 320", done_at); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL full_done_count: got %0d expected 1", done_cnt); end
    n_checks++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL full_busy_after: got %b expected 0", busy_after); end
    exp_line = {64'h3030303030303030, 8'h0a};
    for (int j = 0; j < 9; j++) begin
      got = (bytes_q.size() > j) ? bytes_q[j] : 8'h00;
      n_checks++;
      if (got !== exp_line[71-8*j -: 8]) begin n_fail++; $display("FAIL full_line0[%0d]: got %h expected %h", j, got, exp_line[71-8*j -: 8]); end
    end
    exp_line = {64'h3535353535353535, 8'h0a};
    for (int j = 0; j < 9; j++) begin
      got = (bytes_q.size() > 45 + j) ? bytes_q[45 + j] : 8'h00;
      n_checks++;
      if (got !== exp_line[71-8*j -: 8]) begin n_fail++; $display("FAIL full_line5[%0d]: got %h expected %h", j, got, exp_line[71-8*j -: 8]); end
    end
    exp_line = {64'h6666666666666666, 8'h0a};
    for (int j = 0; j < 9; j++) begin
      got = (bytes_q.size() > 135 + j) ? bytes_q[135 + j] : 8'h00;
      n_checks++;
      if (got !== exp_line[71-8*j -: 8]) begin n_fail++; $display("FAIL full_line15[%0d]: got %h expected %h", j, got, exp_line[71-8*j -: 8]); end
    end
  endtask

  task automatic test_ready_toggle();
    set_pattern();
    regs[1] = 32'hdeadbeef;
    @(negedge clk); start_a = 1'b1;
    capture(1'b0, 1, 2000);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL toggle_timeout: got no done expected done"); end
    n_checks++; if (bytes_q.size() != 288) begin n_fail++; $display("FAIL toggle_bytes: got %0d expected 288", bytes_q.size()); end
    n_checks++; if (stable_err != 0) begin n_fail++; $display("FAIL toggle_stable: got %0d unstable cycles expected 0", stable_err); end
    exp_line = {64'h6465616462656566, 8'h0a};
    for (int j = 0; j < 9; j++) begin
      got = (bytes_q.size() > 9 + j) ? bytes_q[9 + j] : 8'h00;
      n_checks++;
      if (got !== exp_line[71-8*j -: 8]) begin n_fail++; $display("FAIL toggle_line1[%0d]: got %h expected %h", j, got, exp_line[71-8*j -: 8]); end
    end
    exp_line = {64'h3232323232323232, 8'h0a};
    for (int j = 0; j < 9; j++) begin
      got = (bytes_q.size() > 18 + j) ? bytes_q[18 + j] : 8'h00;
      n_checks++;
      if (got !== exp_line[71-8*j -: 8]) begin n_fail++; $display("FAIL toggle_line2[%0d]: got %h expected %h", j, got, exp_line[71-8*j -: 8]); end
    end
  endtask

  task automatic test_ready_hold();
    set_pattern();
    @(negedge clk); start_a = 1'b1;
    capture(1'b0, 2, 1000);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL hold_timeout: got no done expected done"); end
    n_checks++; if (hold_err != 0) begin n_fail++; $display("FAIL hold_stall: got %0d bad cycles expected 0", hold_err); end
    n_checks++; if (bytes_q.size() != 288) begin n_fail++; $display("FAIL hold_bytes: got %0d expected 288", bytes_q.size()); end
    n_checks++; if (done_at != 370) begin n_fail++; $display("FAIL hold_done_cycle: got %0d expected 370", done_at); end
  endtask

  task automatic test_start_spam();
    set_pattern();
    @(negedge clk); start_a = 1'b1;
    capture(1'b0, 3, 1000);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL spam_timeout: got no done expected done"); end
    n_checks++; if (bytes_q.size() != 288) begin n_fail++; $display("FAIL spam_bytes: got %0d expected 288", bytes_q.size()); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL spam_done_count: got %0d expected 1", done_cnt); end
    n_checks++; if (done_at != 320) begin n_fail++; $display("FAIL spam_done_cycle: got %0d expected 320", done_at); end
  endtask

  task automatic test_reset_mid_dump();
    int hs;
    set_pattern();
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    hs = 0;
    for (int k = 0; k < 500; k++) begin
      if (hs == 31) break;
      if (if_a.tx_valid) hs++;
      @(negedge clk);
    end
    n_checks++; if (hs != 31) begin n_fail++; $display("FAIL midrst_reach: got %0d bytes expected 31", hs); end
    n_checks++; if (ra_a !== 5'd3) begin n_fail++; $display("FAIL midrst_ra_before: got %0d expected 3", ra_a); end
    n_checks++; if (if_a.tx_data !== 8'h33) begin n_fail++; $display("FAIL midrst_data_before: got %h expected 33", if_a.tx_data); end
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if ({if_a.tx_valid, if_a.tx_data, ra_a, busy_a, done_a} !== 16'd0) begin
      n_fail++; $display("FAIL midrst_async: got %h expected 0", {if_a.tx_valid, if_a.tx_data, ra_a, busy_a, done_a});
    end
    @(negedge clk); rstn = 1'b1;
    @(negedge clk); start_a = 1'b1;
    capture(1'b0, 0, 1000);
    n_checks++; if (bytes_q.size() != 288) begin n_fail++; $display("FAIL midrst_bytes: got %0d expected 288", bytes_q.size()); end
    exp_line = {64'h3030303030303030, 8'h0a};
    for (int j = 0; j < 9; j++) begin
      got = (bytes_q.size() > j) ? bytes_q[j] : 8'h00;
      n_checks++;
      if (got !== exp_line[71-8*j -: 8]) begin n_fail++; $display("FAIL midrst_line0[%0d]: got %h expected %h", j, got, exp_line[71-8*j -: 8]); end
    end
    exp_line = {64'h3333333333333333, 8'h0a};
    for (int j = 0; j < 9; j++) begin
      got = (bytes_q.size() > 27 + j) ? bytes_q[27 + j] : 8'h00;
      n_checks++;
      if (got !== exp_line[71-8*j -: 8]) begin n_fail++; $display("FAIL midrst_line3[%0d]: got %h expected %h", j, got, exp_line[71-8*j -: 8]); end
    end
  endtask

  task automatic test_num_regs4();
    set_pattern();
    @(negedge clk); start_b = 1'b1;
    capture(1'b1, 0, 200);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL r4_timeout: got no done expected done"); end
    n_checks++; if (bytes_q.size() != 36) begin n_fail++; $display("FAIL r4_bytes: got %0d expected 36", bytes_q.size()); end
    n_checks++; if (done_at != 40) begin n_fail++; $display("FAIL r4_done_cycle: got %0d expected 40", done_at); end
    n_checks++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL r4_busy_after: got %b expected 0", busy_after); end
    exp_line = {64'h3333333333333333, 8'h0a};
    for (int j = 0; j < 9; j++) begin
      got = (bytes_q.size() > 27 + j) ? bytes_q[27 + j] : 8'h00;
      n_checks++;
      if (got !== exp_line[71-8*j -: 8]) begin n_fail++; $display("FAIL r4_last_line[%0d]: got %h expected %h", j, got, exp_line[71-8*j -: 8]); end
    end
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_ready_toggle();
    test_ready_hold();
    test_start_spam();
    test_reset_mid_dump();
    test_num_regs4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
- Debug-side reader for the CPU register file's debug read port (dbg_reg_ra / dbg_reg_rd).
- On a start pulse it walks registers 0..NUM_REGS-1 and captures each value.
- Each value goes out as 8 lowercase hex ASCII characters plus a newline, on a valid/ready byte stream feeding the UART TX path.
- Sits between the register file and the debug UART in the lab SoC top.

Parameters:
- NUM_REGS, 32, number of registers dumped, starting at index 0; legal range 1..32.
- ADDR_W, 5, width of dbg_reg_ra.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- start  input  1  request a dump; sampled only in IDLE.
- dbg_reg_ra  output  ADDR_W  debug read address to the register file.
- dbg_reg_rd  input  32  debug read data; combinational from dbg_reg_ra, valid in the same cycle.
- tx_valid  output  1  byte available on tx_data.
- tx_data  output  8  ASCII byte.
- tx_ready  input  1  sink accepts the byte when tx_valid && tx_ready at a rising edge.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset (asynchronous, rstn=0):
  - State goes to IDLE.
  - idx=0, char_cnt=0, shadow=0.
  - tx_valid=0, tx_data=0, dbg_reg_ra=0, busy=0, done=0.
- Internal registers:
  - idx[ADDR_W-1:0], the current register index.
  - char_cnt[3:0], range 0..8.
  - shadow[31:0], the captured register value.
- dbg_reg_ra = idx at all times (registered).
- States:
  - IDLE: if start=1 at the edge: idx<=0, next state LOAD. A start seen in any other state is ignored; it is not queued.
  - LOAD: at the edge, shadow<=dbg_reg_rd, char_cnt<=0, next state SEND. This takes exactly one cycle. tx_valid=0.
  - SEND: tx_valid=1.
    - char_cnt<8: tx_data = hex(shadow[31:28]). Nibbles 0-9 map to 0x30-0x39; nibbles a-f map to 0x61-0x66.
    - char_cnt==8: tx_data=0x0A.
    - On a handshake with char_cnt<8: shadow<=shadow<<4, char_cnt++.
    - On a handshake with char_cnt==8: if idx==NUM_REGS-1, go to DONE; else idx++ and go to LOAD.
  - DONE: done=1 for this single cycle, then IDLE unconditionally. busy=1 in DONE.
- tx_data and tx_valid stay stable while tx_valid=1 && tx_ready=0. The unit never drops tx_valid before the handshake.
- tx_data is a combinational decode of the registered state, shadow and char_cnt; it has no dependence on tx_ready.
- Timing with tx_ready held at 1:
  - start is sampled at edge E0.
  - The first tx_valid appears after E1.
  - Each register costs 10 cycles (1 LOAD + 9 SEND).
  - done is high in the cycle after the last newline handshake. For NUM_REGS=32 that is 320 cycles after E0.
- Register values are sampled only in LOAD. A write to a register after its LOAD cycle is not reflected in the dump. The stream is a per-register snapshot, not an atomic whole-file snapshot.
- Index 0 is dumped like any other register; the register file returns 0 for it.
- Reset mid-dump aborts immediately: tx_valid drops with no trailing newline, and the next dump restarts at register 0.
- Total bytes per dump = 9*NUM_REGS (288 for the default).

Decomposition:
- Shared package: the state encoding (IDLE, LOAD, SEND, DONE), ASCII constants (ASCII_0=0x30, ASCII_A_LC=0x61, ASCII_LF=0x0A), and CHARS_PER_REG=8.
- One sub-module: nibble_to_hex_ascii, a pure combinational 4-bit to 8-bit map. It is reused by other debug printers.

Test Plan:
- Model register file with x[i]=i*0x11111111 (truncated to 32 bits), tx_ready=1, pulse start. The bench must see:
  - 288 bytes in total.
  - Line 0 "00000000\n".
  - Line 5 "55555555\n".
  - Line 15 "ffffffff\n".
  - done exactly 320 cycles after the start edge, and busy low the following cycle.
- x1=0xDEADBEEF, tx_ready toggling 1-0-1-0. Line 1 must be "deadbeef\n". Each byte must hold stable across its ready=0 cycles, with no duplicated or dropped bytes.
- tx_ready=0 for 50 cycles after the first valid. The bench must see tx_valid=1 and tx_data=0x30 held throughout, and dbg_reg_ra=0 unchanged.
- start pulsed repeatedly during a dump. Exactly one dump of 288 bytes and exactly one done pulse must result.
- rstn asserted mid-line 3. All outputs must go to 0 asynchronously, before the next clock edge. A new start must produce line 0 first.
- NUM_REGS=4 build. The dump must be 36 bytes, with the last line being x3. done must occur 40 cycles after start.
